// File: rtl/crc16_pkg.sv
// Shared constants, state encoding and helpers for the USB CRC16 transmit path.
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        DRAIN,
        NEXT,
        CRC_LO,
        CRC_HI
    } crc_tx_state_t;

    // Reverse bit order of a byte; CRC bytes go out LSB-first like payload.
    function automatic logic [7:0] bitrev8(input logic [7:0] d);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i] = d[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc16_serial_core.sv
// Bit-serial CRC16 engine: non-reflected register, one input bit per enabled cycle.
module crc16_serial_core
    import crc16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic        serial_in,
    output logic [15:0] crc
);

    logic [15:0] q;
    logic        fb;

    assign fb  = q[15] ^ serial_in;
    assign crc = ~q;

    // Preload on reset or clear, otherwise shift one bit with polynomial feedback.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= CRC16_INIT;
        end else if (shift_en) begin
            q <= {q[14:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
        end
    end

endmodule

// File: rtl/crc16_tx_ctrl.sv
// Transmit sequencer: forwards payload bytes, feeds them LSB-first into the
// serial CRC core, then appends the two CRC bytes.
module crc16_tx_ctrl
    import crc16_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic [6:0] byte_cnt,
    output logic       overflow
);

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    crc_tx_state_t state, state_nx;

    logic [2:0]  bit_cnt;
    logic [7:0]  shift_byte;
    logic        last_q;
    logic        accept;
    logic        consumed;
    logic        shift_en;
    logic        clear;
    logic        serial_in;
    logic [15:0] crc;
    logic [6:0]  cnt_inc;
    logic        hit_max;

    assign cnt_inc  = (state == IDLE) ? 7'd1 : byte_cnt + 7'd1;
    assign hit_max  = (cnt_inc == MAX_CNT);
    assign accept   = in_valid & in_ready;
    assign consumed = ~out_valid | out_ready;

    crc16_serial_core u_core (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .shift_en  (shift_en),
        .serial_in (serial_in),
        .crc       (crc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, NEXT: if (accept)            state_nx = SHIFT;
            SHIFT:      if (bit_cnt == 3'd7)   state_nx = DRAIN;
            DRAIN:      if (consumed)          state_nx = last_q ? CRC_LO : NEXT;
            CRC_LO:     if (out_ready)         state_nx = CRC_HI;
            CRC_HI:     if (out_ready)         state_nx = IDLE;
            default:                           state_nx = IDLE;
        endcase
    end

    // State-decoded controls for the input handshake and the CRC core.
    always_comb begin
        in_ready  = ~rst & ((state == IDLE) | (state == NEXT));
        shift_en  = (state == SHIFT);
        clear     = (state == IDLE) & in_valid & ~rst;
        serial_in = shift_byte[bit_cnt];
    end

    // Byte latch, bit counter, byte counter and overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_byte <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            last_q     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            overflow <= accept & ~in_last & hit_max;
            if (accept) begin
                shift_byte <= in_data;
                byte_cnt   <= cnt_inc;
                last_q     <= in_last | hit_max;
                bit_cnt    <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if ((state == CRC_HI) && out_ready) begin
                byte_cnt <= '0;
            end
        end
    end

    // Output register: payload on accept, CRC bytes after the final payload byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
        end else begin
            case (state)
                DRAIN: begin
                    // Last payload byte leaving: reload straight with the low CRC byte.
                    if (consumed && last_q) begin
                        out_data  <= bitrev8(crc[15:8]);
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                CRC_LO: begin
                    if (out_ready) begin
                        out_data <= bitrev8(crc[7:0]);
                        out_last <= 1'b1;
                    end
                end
                CRC_HI: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
